// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority arbiter and its encoder.
package dma_pkg;

  // The arbiter is built for exactly four DREQ channels.
  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDREQ = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational priority encoder.
// Scans the effective request vector starting at i_base and wrapping modulo
// NUM_CH. It returns the first channel that has a request set.
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] i_eff,
  input  ch_idx_t           i_base,
  output logic              o_found,
  output ch_idx_t           o_winner
);

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    ch_idx_t v_idx;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_found  = 1'b0;
    o_winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      v_idx = i_base + ch_idx_t'(k);
      if (i_eff[v_idx]) begin
        o_found  = 1'b1;
        o_winner = v_idx;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237-style DMA channel priority arbiter.
// It raises HRQ for pending requests and grants one channel once HLDA is
// returned. The grant is held until TransferDone arrives. The arbiter then
// passes through RELEASE, so HRQ drops between services.
module dma_priority_arbiter #(
  parameter int NUM_CH = dma_pkg::NUM_CH
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic [NUM_CH-1:0]   SoftwareReq,
  input  logic [NUM_CH-1:0]   MaskBits,
  input  logic                DreqSenseLow,
  input  logic                DackSenseHigh,
  input  logic                RotatingPri,
  input  logic                ControllerDisable,
  input  logic                HLDA,
  input  logic                TransferDone,
  output logic                HRQ,
  output logic [NUM_CH-1:0]   DACK,
  output logic                GrantValid,
  output dma_pkg::ch_idx_t    GrantChannel
);

  import dma_pkg::*;

  logic [NUM_CH-1:0] w_eff;
  logic              w_any;
  ch_idx_t           w_base;
  ch_idx_t           w_winner;
  logic [NUM_CH-1:0] w_dack_onehot;

  arb_state_t        r_state;
  logic              r_hrq;
  logic              r_grant_valid;
  ch_idx_t           r_grant_ch;
  ch_idx_t           r_ptr;

  // A software request always counts. A hardware DREQ counts only when its mask bit is clear.
  assign w_eff  = ((DREQ ^ {NUM_CH{DreqSenseLow}}) & ~MaskBits) | SoftwareReq;

  // In fixed-priority mode the scan always starts at channel 0.
  assign w_base = RotatingPri ? r_ptr : '0;

  dma_prio_encoder u_prio_encoder (
    .i_eff    (w_eff),
    .i_base   (w_base),
    .o_found  (w_any),
    .o_winner (w_winner)
  );

  // Arbitration FSM. All outputs are registered, and the rotation pointer advances on every service exit.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state       <= ST_IDLE;
      r_hrq         <= 1'b0;
      r_grant_valid <= 1'b0;
      r_grant_ch    <= '0;
      r_ptr         <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      unique case (r_state)
        ST_IDLE: begin
          if (w_any && !ControllerDisable) begin
            r_state <= ST_HOLDREQ;
            r_hrq   <= 1'b1;
          end
        end
        ST_HOLDREQ: begin
          // HRQ stays high until HLDA arrives, even if every request has been withdrawn.
          if (HLDA) begin
            if (w_any) begin
              r_state       <= ST_SERVICE;
              r_grant_valid <= 1'b1;
              r_grant_ch    <= w_winner;
            end else begin
              r_state <= ST_RELEASE;
              r_hrq   <= 1'b0;
            end
          end
        end
        ST_SERVICE: begin
          // The grant is frozen. Only TransferDone ends the service.
          if (TransferDone) begin
            r_state       <= ST_RELEASE;
            r_hrq         <= 1'b0;
            r_grant_valid <= 1'b0;
            r_ptr         <= r_grant_ch + 2'd1;
          end
        end
        ST_RELEASE: begin
          // Wait for the CPU to take the bus back before re-arbitrating.
          if (!HLDA) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // DACK is derived from registered state, so reset forces it inactive without waiting for a clock edge.
  always_comb begin
    w_dack_onehot = '0;
    if (r_grant_valid) begin
      w_dack_onehot[r_grant_ch] = 1'b1;
    end
  end

  assign DACK         = w_dack_onehot ^ {NUM_CH{~DackSenseHigh}};
  assign HRQ          = r_hrq;
  assign GrantValid   = r_grant_valid;
  assign GrantChannel = r_grant_ch;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter.
// The driver pushes the expected grant at the moment HLDA is returned. A
// separate monitor pops and compares each new grant.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic [3:0] DREQ, SoftwareReq, MaskBits;
  logic       DreqSenseLow, DackSenseHigh, RotatingPri, ControllerDisable;
  logic       HLDA, TransferDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       GrantValid;
  logic [1:0] GrantChannel;

  typedef struct {
    int         ch;
    logic [3:0] dack;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   m_ptr  = 0;   // model rotation pointer
  int   cur_ch = 0;
  bit   prev_gv = 1'b0;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK               (CLK),
    .nRESET            (nRESET),
    .DREQ              (DREQ),
    .SoftwareReq       (SoftwareReq),
    .MaskBits          (MaskBits),
    .DreqSenseLow      (DreqSenseLow),
    .DackSenseHigh     (DackSenseHigh),
    .RotatingPri       (RotatingPri),
    .ControllerDisable (ControllerDisable),
    .HLDA              (HLDA),
    .TransferDone      (TransferDone),
    .HRQ               (HRQ),
    .DACK              (DACK),
    .GrantValid        (GrantValid),
    .GrantChannel      (GrantChannel)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the effective request rule, a rotating scan and the DACK polarity.
  function automatic logic [3:0] model_eff();
    logic [3:0] e;
    logic       raw;
    for (int i = 0; i < 4; i++) begin
      raw  = DreqSenseLow ? ~DREQ[i] : DREQ[i];
      e[i] = SoftwareReq[i] | (raw & ~MaskBits[i]);
    end
    return e;
  endfunction

  function automatic int model_winner(input logic [3:0] e);
    int base;
    base = RotatingPri ? m_ptr : 0;
    for (int k = 0; k < 4; k++) begin
      if (e[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] inactive_dack();
    return DackSenseHigh ? 4'h0 : 4'hF;
  endfunction

  function automatic logic [3:0] dack_of(input int ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    return oh ^ inactive_dack();
  endfunction

  // Monitor: on every newly asserted grant, pop the scoreboard and compare the grant. Then check that the grant holds.
  always @(negedge CLK) begin
    exp_t e;
    if (!nRESET) begin
      prev_gv = 1'b0;
    end else begin
      if (GrantValid && !prev_gv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 8'(GrantValid), 8'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_ch", 8'(GrantChannel), 8'(e.ch));
          check("grant_dack", 8'(DACK), 8'(e.dack));
          cur_ch = e.ch;
        end
      end else if (GrantValid) begin
        check("grant_hold", 8'(GrantChannel), 8'(cur_ch));
      end
      prev_gv = GrantValid;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_hrq();
    int n;
    n = 0;
    while (!HRQ && n < 30) begin
      tick();
      n++;
    end
    check("hrq_rise", 8'(HRQ), 8'd1);
  endtask

  // One bus handshake: wait for HRQ, return HLDA two cycles later, service, then release.
  task automatic serve(input bit perturb);
    logic [3:0] e;
    int         w;
    exp_t       x;
    wait_hrq();
    if (!HRQ) return;
    tick();
    tick();
    e = model_eff();
    w = model_winner(e);
    if (e == 4'b0) begin
      HLDA = 1'b1;
      tick();
      check("release_no_gv", 8'(GrantValid), 8'd0);
      check("release_hrq", 8'(HRQ), 8'd0);
      check("release_dack", 8'(DACK), 8'(inactive_dack()));
      tick();
      check("release_hold_hrq", 8'(HRQ), 8'd0);
      HLDA = 1'b0;
      tick();
      return;
    end
    x.ch   = w;
    x.dack = dack_of(w);
    exp_q.push_back(x);
    HLDA = 1'b1;
    tick();
    check("gv_on", 8'(GrantValid), 8'd1);
    repeat ($urandom_range(1, 4)) begin
      if (perturb) begin
        DREQ              = 4'($urandom);
        MaskBits          = 4'($urandom);
        ControllerDisable = 1'($urandom);
      end
      tick();
    end
    TransferDone = 1'b1;
    tick();
    TransferDone = 1'b0;
    m_ptr = (w + 1) % 4;
    check("done_hrq", 8'(HRQ), 8'd0);
    check("done_gv", 8'(GrantValid), 8'd0);
    check("done_dack", 8'(DACK), 8'(inactive_dack()));
    repeat ($urandom_range(0, 2)) tick();
    check("release_gap_hrq", 8'(HRQ), 8'd0);
    HLDA = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t x;
    nRESET = 1'b0; DREQ = '0; SoftwareReq = '0; MaskBits = '0;
    DreqSenseLow = 1'b0; DackSenseHigh = 1'b0; RotatingPri = 1'b0;
    ControllerDisable = 1'b0; HLDA = 1'b0; TransferDone = 1'b0;
    #12;
    check("rst_hrq", 8'(HRQ), 8'd0);
    check("rst_gv", 8'(GrantValid), 8'd0);
    check("rst_ch", 8'(GrantChannel), 8'd0);
    check("rst_dack", 8'(DACK), 8'hF);
    nRESET = 1'b1;
    tick();

    // Fixed priority: channel 1 beats channel 3, then channel 3 alone.
    DREQ = 4'b1010;
    serve(1'b0);
    DREQ = 4'b1000;
    serve(1'b0);
    DREQ = 4'b0000;

    // Rotating priority: all requests held, five services.
    RotatingPri = 1'b1;
    DREQ = 4'b1111;
    repeat (5) serve(1'b0);
    DREQ = 4'b0000;
    RotatingPri = 1'b0;

    // Masked DREQ is ignored. A software request is never masked.
    MaskBits = 4'b0001;
    DREQ = 4'b0001;
    repeat (5) tick();
    check("mask_blocks_hrq", 8'(HRQ), 8'd0);
    SoftwareReq = 4'b0001;
    serve(1'b0);
    SoftwareReq = 4'b0000;
    MaskBits = 4'b0000;
    DREQ = 4'b0000;

    // The request is withdrawn before HLDA. HRQ must hold, and no grant may be issued.
    DREQ = 4'b0100;
    wait_hrq();
    DREQ = 4'b0000;
    repeat (3) tick();
    check("withdrawn_hrq_held", 8'(HRQ), 8'd1);
    serve(1'b0);

    // Reset mid-service: the outputs must drop before the next edge, and the pointer returns to 0.
    RotatingPri = 1'b1;
    DREQ = 4'b0100;
    wait_hrq();
    tick();
    tick();
    x.ch   = model_winner(model_eff());
    x.dack = dack_of(x.ch);
    exp_q.push_back(x);
    HLDA = 1'b1;
    tick();
    tick();
    #1 nRESET = 1'b0;
    #1;
    check("midrst_hrq", 8'(HRQ), 8'd0);
    check("midrst_dack", 8'(DACK), 8'hF);
    check("midrst_gv", 8'(GrantValid), 8'd0);
    check("midrst_ch", 8'(GrantChannel), 8'd0);
    exp_q.delete();
    m_ptr = 0;
    HLDA = 1'b0;
    DREQ = 4'b0000;
    tick();
    nRESET = 1'b1;
    tick();
    DREQ = 4'b1111;
    serve(1'b0);
    DREQ = 4'b0000;
    RotatingPri = 1'b0;

    // Inverted polarities: active-low DREQ, active-high DACK.
    DreqSenseLow = 1'b1;
    DackSenseHigh = 1'b1;
    DREQ = 4'b1011;
    serve(1'b0);
    DREQ = 4'b1111;

    // Randomized services, with input disturbance during SERVICE.
    repeat (30) begin
      RotatingPri       = 1'($urandom);
      DreqSenseLow      = 1'($urandom);
      DackSenseHigh     = 1'($urandom);
      MaskBits          = 4'($urandom);
      SoftwareReq       = 4'($urandom) & 4'($urandom);
      DREQ              = 4'($urandom);
      ControllerDisable = 1'b0;
      if (model_eff() == 4'b0) SoftwareReq[$urandom_range(0, 3)] = 1'b1;
      serve(1'b1);
    end

    repeat (3) tick();
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
